if_fetch_unit: RTL and testbench

//  Instruction-fetch stage driven by the CU sequencer one-hot stage strobes. Holds the PC.
//  On an IF_clk strobe, issues a req/ack read to instruction memory and latches the returned word for ID.
//  On a BR_clk strobe, advances the PC: +PC_STEP, or the branch target when taken.

---
 rtl/if_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues one req/ack read per IF_clk
// strobe and latches the returned word for decode. BR_clk advances the PC.
// Optional feature macro: FETCH_TIMEOUT_EN (bounded WAIT plus sticky fetch_fault).
//
// state  | meaning
// -------+---------------------------------------------
// S_IDLE | no fetch outstanding, imem_req low
// S_WAIT | request issued, waiting for imem_ack
module if_fetch_unit #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic          cpu_clk,
    input  logic          reset,
    input  logic          IF_clk,
    input  logic          BR_clk,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc_out,
    output logic          instr_valid,
    output logic          busy,
`ifdef FETCH_TIMEOUT_EN
    output logic          fetch_fault,
`endif
    output logic          overrun_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          overrun_q, overrun_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
`endif

    // Next-state logic for the fetch FSM and the PC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        req_d     = req_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        overrun_d = overrun_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d     = cnt_q;
        fault_d   = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (IF_clk) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = pc_q;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // A strobe arriving mid-fetch is dropped, only flagged.
                if (IF_clk) begin
                    overrun_d = 1'b1;
                end
                if (imem_ack) begin
                    state_d = S_IDLE;
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        // PC update is independent of the fetch; a fetch started on the
        // same edge already captured the old PC above.
        if (BR_clk) begin
            pc_d = br_taken ? br_target : pc_q + AW'(PC_STEP);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= AW'(RESET_PC);
            addr_q    <= '0;
            instr_q   <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q     <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign pc_out      = pc_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign overrun_err = overrun_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_fault = fault_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a table of per-edge vectors plus
// hand-written reset-mid-fetch and (optional) timeout sequences.
module tb_if_fetch_unit;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        IF_clk, BR_clk, br_taken, imem_ack;
    logic [31:0] br_target, imem_rdata;
    logic        imem_req, instr_valid, busy, overrun_err;
    logic [31:0] imem_addr, instr, pc_out;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_fault;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    if_fetch_unit dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .IF_clk     (IF_clk),
        .BR_clk     (BR_clk),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc_out     (pc_out),
        .instr_valid(instr_valid),
        .busy       (busy),
`ifdef FETCH_TIMEOUT_EN
        .fetch_fault(fetch_fault),
`endif
        .overrun_err(overrun_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        if_s, br_s, taken;
        logic [31:0] target;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_valid, e_busy, e_ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic i, logic b, logic t, logic [31:0] tg, logic a,
                                logic [31:0] rd, logic [31:0] pc, logic rq,
                                logic [31:0] ad, logic [31:0] ins, logic v,
                                logic bz, logic ov);
        vec_t r;
        r.if_s = i; r.br_s = b; r.taken = t; r.target = tg; r.ack = a; r.rdata = rd;
        r.e_pc = pc; r.e_req = rq; r.e_addr = ad; r.e_instr = ins;
        r.e_valid = v; r.e_busy = bz; r.e_ovr = ov;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic i, logic b, logic t, logic [31:0] tg, logic a, logic [31:0] rd);
        IF_clk = i; BR_clk = b; br_taken = t; br_target = tg; imem_ack = a; imem_rdata = rd;
    endtask

    task automatic edge_and_settle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check_all(int idx, logic [31:0] pc, logic rq, logic [31:0] ad,
                             logic [31:0] ins, logic v, logic bz, logic ov);
        chk("pc_out", idx, pc_out, pc);
        chk("imem_req", idx, 32'(imem_req), 32'(rq));
        chk("imem_addr", idx, imem_addr, ad);
        chk("instr", idx, instr, ins);
        chk("instr_valid", idx, 32'(instr_valid), 32'(v));
        chk("busy", idx, 32'(busy), 32'(bz));
        chk("overrun_err", idx, 32'(overrun_err), 32'(ov));
    endtask

    initial begin
        //                 IF BR tk target        ack rdata         pc            req addr          instr         v  bz ov
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00A00093, 32'h0,        0, 32'h0,        32'h00A00093, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h00A00093, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        0, 32'h0,        32'h00A00093, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        0, 32'h0,        32'h00A00093, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hC,        1, 32'h8,        32'h00A00093, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h11111111, 32'hC,        0, 32'h8,        32'h11111111, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h10,       0, 32'h8,        32'h11111111, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h14,       0, 32'h8,        32'h11111111, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,        32'h200,      0, 32'h8,        32'h11111111, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h200,      1, 32'h200,      32'h11111111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hDEADBEEF, 32'h200,      1, 32'h200,      32'h11111111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hDEADBEEF, 32'h200,      1, 32'h200,      32'h11111111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'hDEADBEEF, 32'h200,      1, 32'h200,      32'h11111111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h22222222, 32'h200,      0, 32'h200,      32'h22222222, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h200,      0, 32'h200,      32'h22222222, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,        32'hFFFFFFFC, 0, 32'h200,      32'h22222222, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h200,      32'h22222222, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        32'h22222222, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        32'h22222222, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0,        32'h22222222, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h33333333, 32'h4,        0, 32'h0,        32'h33333333, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h44444444, 32'h4,        0, 32'h0,        32'h33333333, 0, 0, 1));

        drive(0, 0, 0, 32'h0, 0, 32'h0);
        reset = 1'b1;
        @(posedge cpu_clk);
        edge_and_settle();
        check_all(-1, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
        chk("fetch_fault_rst", -1, 32'(fetch_fault), 32'h0);
`endif
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].if_s, vecs[i].br_s, vecs[i].taken, vecs[i].target,
                  vecs[i].ack, vecs[i].rdata);
            edge_and_settle();
            check_all(i, vecs[i].e_pc, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
                      vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_ovr);
        end

        // Reset mid-fetch: request drops at the reset edge, a later ack is ignored.
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        edge_and_settle();
        chk("midrst_req_before", 100, 32'(imem_req), 32'h1);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        reset = 1'b1;
        edge_and_settle();
        check_all(101, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 1, 32'h55555555);
        edge_and_settle();
        check_all(102, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        edge_and_settle();
        check_all(103, 32'h0, 0, 32'h0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // No ack for 15 WAIT cycles ends the fetch with a sticky fault.
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        edge_and_settle();
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 14; k++) edge_and_settle();
        chk("to_req_held", 200, 32'(imem_req), 32'h1);
        chk("to_fault_early", 200, 32'(fetch_fault), 32'h0);
        edge_and_settle();
        chk("to_req_drop", 201, 32'(imem_req), 32'h0);
        chk("to_fault", 201, 32'(fetch_fault), 32'h1);
        chk("to_valid", 201, 32'(instr_valid), 32'h0);
        chk("to_instr", 201, instr, 32'h0);
        edge_and_settle();
        chk("to_fault_sticky", 202, 32'(fetch_fault), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
